// File: rtl/alu_exc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_exc_pkg
// Brief   : Cause codes, FSM state encoding and mask bit indices shared by the
//           ALU exception unit and its priority encoder.
// Revision: 1.0 - initial release
// ============================================================================
package alu_exc_pkg;

    localparam logic [3:0] CAUSE_NONE   = 4'd0;
    localparam logic [3:0] CAUSE_OF     = 4'd1;
    localparam logic [3:0] CAUSE_UF     = 4'd2;
    localparam logic [3:0] CAUSE_DIV    = 4'd3;
    localparam logic [3:0] CAUSE_DFAULT = 4'd4;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_TRAP    = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    // Bit positions inside exc_mask, sticky_status and the error vector
    localparam int MASK_OF  = 0;
    localparam int MASK_UF  = 1;
    localparam int MASK_DIV = 2;

endpackage
`default_nettype wire

// File: rtl/exc_priority_enc.sv
`default_nettype none
// ============================================================================
// Module  : exc_priority_enc
// Brief   : Maps a 3-bit {DIV,UF,OF} source vector to a cause code, DIV > OF > UF.
// Revision: 1.0 - initial release
// ============================================================================
module exc_priority_enc
    import alu_exc_pkg::*;
(
    input  logic [2:0] src,
    output logic [3:0] cause
);

    always_comb begin
        cause = CAUSE_NONE;
        if (src[MASK_DIV])
            cause = CAUSE_DIV;
        else if (src[MASK_OF])
            cause = CAUSE_OF;
        else if (src[MASK_UF])
            cause = CAUSE_UF;
    end

endmodule
`default_nettype wire

// File: rtl/alu_exception_unit.sv
`default_nettype none
// ============================================================================
// Module  : alu_exception_unit
// Brief   : Traps ALU overflow/underflow/divide faults, captures EPC and cause,
//           redirects to the handler and escalates handler faults to halt.
// Revision: 1.0 - initial release
// ============================================================================
module alu_exception_unit
    import alu_exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      pc_current,
    input  logic [5:0]       alu_op,
    input  logic             error_of,
    input  logic             error_uf,
    input  logic             error_div,
    input  logic [2:0]       exc_mask,
    input  logic             eret,
    input  logic             clear_sticky,
    output logic             write_inhibit,
    output logic             trap_taken,
    output logic [31:0]      handler_pc,
    output logic             in_handler,
    output logic             halted,
    output logic [31:0]      epc,
    output logic [3:0]       cause,
    output logic [5:0]       bad_op,
    output logic [2:0]       sticky_status,
    output logic [CNT_W-1:0] fault_count
);

    logic [1:0]       r_state;
    logic             r_trap_taken;
    logic             r_in_handler;
    logic             r_halted;
    logic [31:0]      r_epc;
    logic [3:0]       r_cause;
    logic [5:0]       r_bad_op;
    logic [2:0]       r_sticky;
    logic [CNT_W-1:0] r_fault_count;

    logic [2:0]       w_err_vec;
    logic [2:0]       w_live;
    logic [3:0]       w_live_cause;

    assign w_err_vec = {error_div, error_uf, error_of} & {3{instr_valid}};
    assign w_live    = w_err_vec & exc_mask;

    exc_priority_enc u_prio (
        .src   (w_live),
        .cause (w_live_cause)
    );

    always_comb begin
        write_inhibit = 1'b0;
        case (r_state)
            ST_RUN:     write_inhibit = |w_live;
            ST_HANDLER: write_inhibit = |w_err_vec;
            default:    write_inhibit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_trap_taken  <= 1'b0;
            r_in_handler  <= 1'b0;
            r_halted      <= 1'b0;
            r_epc         <= 32'd0;
            r_cause       <= CAUSE_NONE;
            r_bad_op      <= 6'd0;
            r_sticky      <= 3'd0;
            r_fault_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_sticky <= clear_sticky ? w_err_vec : (r_sticky | w_err_vec);
                    if (|w_live) begin
                        r_state      <= ST_TRAP;
                        r_trap_taken <= 1'b1;
                        r_in_handler <= 1'b1;
                        r_epc        <= pc_current;
                        r_bad_op     <= alu_op;
                        r_cause      <= w_live_cause;
                        if (r_fault_count != {CNT_W{1'b1}})
                            r_fault_count <= r_fault_count + 1'b1;
                    end
                end
                ST_TRAP: begin
                    // The committing slot is squashed, so its error flags are not recorded
                    if (clear_sticky)
                        r_sticky <= 3'd0;
                    r_state      <= ST_HANDLER;
                    r_trap_taken <= 1'b0;
                end
                ST_HANDLER: begin
                    r_sticky <= clear_sticky ? w_err_vec : (r_sticky | w_err_vec);
                    if (|w_err_vec) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= CAUSE_DFAULT;
                    end else if (eret) begin
                        r_state      <= ST_RUN;
                        r_in_handler <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign trap_taken    = r_trap_taken;
    assign in_handler    = r_in_handler;
    assign halted        = r_halted;
    assign handler_pc    = HANDLER_ADDR;
    assign epc           = r_epc;
    assign cause         = r_cause;
    assign bad_op        = r_bad_op;
    assign sticky_status = r_sticky;
    assign fault_count   = r_fault_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_exception_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_exception_unit
// Brief   : Directed scoreboard bench for alu_exception_unit (CNT_W = 2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_exception_unit;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_valid;
    logic [31:0]      pc_current;
    logic [5:0]       alu_op;
    logic             error_of, error_uf, error_div;
    logic [2:0]       exc_mask;
    logic             eret;
    logic             clear_sticky;
    logic             write_inhibit;
    logic             trap_taken;
    logic [31:0]      handler_pc;
    logic             in_handler;
    logic             halted;
    logic [31:0]      epc;
    logic [3:0]       cause;
    logic [5:0]       bad_op;
    logic [2:0]       sticky_status;
    logic [CNT_W-1:0] fault_count;

    alu_exception_unit #(.HANDLER_ADDR(32'h0000_0080), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .pc_current    (pc_current),
        .alu_op        (alu_op),
        .error_of      (error_of),
        .error_uf      (error_uf),
        .error_div     (error_div),
        .exc_mask      (exc_mask),
        .eret          (eret),
        .clear_sticky  (clear_sticky),
        .write_inhibit (write_inhibit),
        .trap_taken    (trap_taken),
        .handler_pc    (handler_pc),
        .in_handler    (in_handler),
        .halted        (halted),
        .epc           (epc),
        .cause         (cause),
        .bad_op        (bad_op),
        .sticky_status (sticky_status),
        .fault_count   (fault_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             tt;
        logic             ih;
        logic             hl;
        logic [31:0]      epc;
        logic [3:0]       cause;
        logic [5:0]       op;
        logic [2:0]       sticky;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];

    // Reference model: state 0 RUN, 1 TRAP, 2 HANDLER, 3 HALT
    int               m_st;
    logic [31:0]      m_epc;
    logic [3:0]       m_cause;
    logic [5:0]       m_op;
    logic [2:0]       m_sticky;
    logic [CNT_W-1:0] m_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.tt     = (m_st == 1);
        e.ih     = (m_st != 0);
        e.hl     = (m_st == 3);
        e.epc    = m_epc;
        e.cause  = m_cause;
        e.op     = m_op;
        e.sticky = m_sticky;
        e.cnt    = m_cnt;
        return e;
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        check({tag, ".trap_taken"}, 32'(trap_taken), 32'(e.tt));
        check({tag, ".in_handler"}, 32'(in_handler), 32'(e.ih));
        check({tag, ".halted"},     32'(halted),     32'(e.hl));
        check({tag, ".epc"},        epc,             e.epc);
        check({tag, ".cause"},      32'(cause),      32'(e.cause));
        check({tag, ".bad_op"},     32'(bad_op),     32'(e.op));
        check({tag, ".sticky"},     32'(sticky_status), 32'(e.sticky));
        check({tag, ".count"},      32'(fault_count),   32'(e.cnt));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        m_st = 0; m_epc = '0; m_cause = '0; m_op = '0; m_sticky = '0; m_cnt = '0;
        q.push_back(model_out());
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_pop(tag);
        check({tag, ".handler_pc"}, handler_pc, 32'h0000_0080);
    endtask

    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic [5:0] op, input logic [2:0] flags_du_o,
                        input logic [2:0] mask, input logic er, input logic clr);
        logic [2:0] ev;
        logic [2:0] live;
        logic       wi;
        @(negedge clk);
        instr_valid  = iv;
        pc_current   = pc;
        alu_op       = op;
        error_div    = flags_du_o[2];
        error_uf     = flags_du_o[1];
        error_of     = flags_du_o[0];
        exc_mask     = mask;
        eret         = er;
        clear_sticky = clr;
        ev   = iv ? flags_du_o : 3'b000;
        live = ev & mask;
        wi   = (m_st == 0 && live != 0) || (m_st == 2 && ev != 0) || m_st == 1 || m_st == 3;
        #1;
        check({tag, ".write_inhibit"}, 32'(write_inhibit), 32'(wi));
        case (m_st)
            0: begin
                m_sticky = clr ? ev : (m_sticky | ev);
                if (live != 0) begin
                    m_epc = pc;
                    m_op  = op;
                    m_cause = live[2] ? 4'd3 : (live[0] ? 4'd1 : 4'd2);
                    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                    m_st = 1;
                end
            end
            1: begin
                if (clr) m_sticky = 3'b000;
                m_st = 2;
            end
            2: begin
                m_sticky = clr ? ev : (m_sticky | ev);
                if (ev != 0) begin
                    m_cause = 4'd4;
                    m_st = 3;
                end else if (er) begin
                    m_st = 0;
                end
            end
            default: ;
        endcase
        q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    initial begin
        reset = 1'b0; instr_valid = 1'b0; pc_current = '0; alu_op = '0;
        error_of = 1'b0; error_uf = 1'b0; error_div = 1'b0;
        exc_mask = 3'b111; eret = 1'b0; clear_sticky = 1'b0;

        do_reset("reset0");

        // Overflow trap, then three clean handler cycles and eret
        step("of_trap",  1'b1, 32'h40, 6'h00, 3'b001, 3'b111, 1'b0, 1'b0);
        step("of_slot",  1'b1, 32'h44, 6'h01, 3'b000, 3'b111, 1'b0, 1'b0);
        step("hnd1",     1'b1, 32'h80, 6'h02, 3'b000, 3'b111, 1'b0, 1'b0);
        step("hnd2",     1'b1, 32'h84, 6'h02, 3'b000, 3'b111, 1'b0, 1'b0);
        step("hnd3",     1'b1, 32'h88, 6'h02, 3'b000, 3'b111, 1'b0, 1'b0);
        step("eret1",    1'b1, 32'h8c, 6'h3f, 3'b000, 3'b111, 1'b1, 1'b0);
        step("clean",    1'b1, 32'h48, 6'h05, 3'b000, 3'b111, 1'b0, 1'b0);
        step("eret_run", 1'b1, 32'h4c, 6'h05, 3'b000, 3'b111, 1'b1, 1'b0);

        // DIV and UF together; DIV wins, clear_sticky keeps only the new sources
        step("divuf",    1'b1, 32'h100, 6'h1a, 3'b110, 3'b111, 1'b0, 1'b1);
        step("divuf_sl", 1'b0, 32'h104, 6'h00, 3'b000, 3'b111, 1'b1, 1'b0);
        step("eret2",    1'b1, 32'h80,  6'h3f, 3'b000, 3'b111, 1'b1, 1'b0);

        // Masked fault, clear with simultaneous new error, invalid instruction
        step("masked",   1'b1, 32'h200, 6'h00, 3'b001, 3'b110, 1'b0, 1'b0);
        step("clr_uf",   1'b1, 32'h204, 6'h01, 3'b010, 3'b000, 1'b0, 1'b1);
        step("invalid",  1'b0, 32'h208, 6'h0f, 3'b111, 3'b111, 1'b0, 1'b0);

        // Double fault: DIV plus eret in the handler
        step("uf_trap",  1'b1, 32'h300, 6'h11, 3'b010, 3'b111, 1'b0, 1'b0);
        step("uf_slot",  1'b1, 32'h304, 6'h00, 3'b000, 3'b111, 1'b0, 1'b0);
        step("hnd_ok",   1'b1, 32'h80,  6'h00, 3'b000, 3'b111, 1'b0, 1'b0);
        step("dfault",   1'b1, 32'h84,  6'h22, 3'b100, 3'b000, 1'b1, 1'b0);
        step("halt_er",  1'b1, 32'h88,  6'h00, 3'b000, 3'b111, 1'b1, 1'b0);
        step("halt_err", 1'b1, 32'h8c,  6'h33, 3'b111, 3'b111, 1'b0, 1'b1);

        do_reset("reset1");

        // Saturating counter: five trap/eret sequences
        for (int i = 0; i < 5; i++) begin
            step("sat_trap", 1'b1, 32'h400 + 32'(i * 4), 6'(i + 1), 3'b001, 3'b111, 1'b0, 1'b0);
            step("sat_slot", 1'b1, 32'h500, 6'h00, 3'b000, 3'b111, 1'b0, 1'b0);
            step("sat_eret", 1'b1, 32'h80,  6'h3f, 3'b000, 3'b111, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exception_unit.md
Name: alu_exception_unit

Overview:
- Sits directly downstream of the ALU and consumes its error_of / error_uf / error_div flags for the committing instruction.
- Classifies the fault, captures EPC and cause, and inhibits register write-back of the faulting result.
- Redirects the PC to a fixed handler vector and tracks handler residency until eret.
- Escalates a fault raised inside the handler (double fault) to a permanent halt.

Parameters:
- HANDLER_ADDR, 32'h0000_0080, PC loaded on trap.
- CNT_W, 8, width of the saturating trapped-fault counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  an instruction commits this cycle
- pc_current  input  32  PC of the committing instruction
- alu_op  input  6  ALUOp of the committing instruction
- error_of  input  1  ALU add overflow
- error_uf  input  1  ALU sub underflow
- error_div  input  1  ALU divide/rem by zero
- exc_mask  input  3  per-source enable, bit0 OF, bit1 UF, bit2 DIV; 1 = trap
- eret  input  1  handler return, decoded eret committing
- clear_sticky  input  1  clears sticky_status
- write_inhibit  output  1  combinational; suppresses reg-file and memory write this cycle
- trap_taken  output  1  registered one-cycle pulse; next-PC mux selects handler_pc
- handler_pc  output  32  constant HANDLER_ADDR
- in_handler  output  1  high from the trap cycle until eret
- halted  output  1  double fault; core stalls until reset
- epc  output  32  PC of the trapped instruction
- cause  output  4  0 none, 1 OF, 2 UF, 3 DIV, 4 double fault
- bad_op  output  6  alu_op of the trapped instruction
- sticky_status  output  3  accumulated error sources {DIV,UF,OF}, masked or not
- fault_count  output  CNT_W  number of trapped faults, saturating

Behaviour:
- Reset (synchronous, active-high): state RUN; trap_taken, in_handler, halted = 0; epc = 0; cause = 0; bad_op = 0; sticky_status = 0; fault_count = 0. Reset overrides every other input in any state, including mid-trap and HALT.
- Definitions:
  - err_vec = {error_div, error_uf, error_of} & {3{instr_valid}}
  - live = err_vec & exc_mask
- Priority when several sources are live: DIV > OF > UF.
- sticky_status <= clear_sticky ? err_vec : (sticky_status | err_vec). A new error set in the same cycle as clear_sticky therefore survives.
- FSM states: RUN, TRAP, HANDLER, HALT.
- RUN:
  - If live != 0: epc <= pc_current; bad_op <= alu_op; cause <= prioritized code; fault_count++ (saturating at all-ones); go to TRAP.
  - Masked-only errors update sticky_status only; no trap.
- TRAP: lasts exactly 1 cycle.
  - trap_taken = 1 and in_handler = 1.
  - instr_valid is ignored; the core squashes this slot.
  - Always advances to HANDLER.
- HANDLER:
  - in_handler = 1.
  - If any err_vec bit is set, regardless of mask: cause <= 4, epc held, go to HALT.
  - Else if eret: go to RUN and clear in_handler.
  - An error and eret in the same cycle: error wins, go to HALT.
  - epc and cause are stable for the whole handler.
- HALT: halted = 1 and in_handler = 1. All inputs are ignored except reset. This state is terminal.
- write_inhibit:
  - High if (state == RUN and live != 0), or (state == HANDLER and err_vec != 0), or state == TRAP, or state == HALT.
  - Zero latency, combinational.
- eret in RUN or TRAP is ignored.
- Latency: fault in cycle N gives trap_taken in cycle N+1 and the first handler instruction in cycle N+2.
- fault_count counts RUN-state traps only and saturates at 2^CNT_W-1 without wrap.

Decomposition:
- Shared package (alu_exc_pkg):
  - cause codes: CAUSE_NONE, CAUSE_OF, CAUSE_UF, CAUSE_DIV, CAUSE_DFAULT
  - FSM state enum
  - mask bit indices
- One natural sub-module, exc_priority_enc: combinational 3-bit to cause-code encoder. It is reusable by the future interrupt controller.

Test Plan:
- Add overflow with exc_mask=3'b111: instr_valid=1, error_of=1, pc_current=32'h0000_0040, alu_op=6'h00 -> write_inhibit=1 same cycle; next cycle trap_taken=1; epc=32'h40, cause=1, bad_op=0, fault_count=1; then HANDLER.
- Simultaneous error_div=1 and error_uf=1 -> cause=3 (DIV); sticky_status=3'b110.
- Masked fault: exc_mask=3'b110 with error_of=1 -> no trap; write_inhibit=0; sticky_status=3'b001. Then clear_sticky=1 with error_uf=1 in the same cycle -> sticky_status=3'b010.
- Double fault: in HANDLER, assert error_div=1 and eret=1 in the same cycle -> halted=1, cause=4, epc unchanged. Later eret/errors have no effect. reset=1 for one cycle -> all outputs 0, state RUN.
- Normal return: trap, then 3 clean handler cycles, then eret=1 -> in_handler=0 next cycle. A subsequent clean instruction gives write_inhibit=0, trap_taken=0.
- Saturation: with CNT_W=2, drive 5 trap/eret sequences -> fault_count reads 1,2,3,3,3. Also check instr_valid=0 with error flags high -> no effect on any state.
